// File: rtl/rob_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// rob_alloc_ctrl
//
// Reorder-buffer allocation / commit controller for a two-wide pipeline.
// Tracks head, tail and occupancy of a circular ROB. It hands out tail
// indices to the dispatch slots and retires up to two entries per cycle,
// strictly in order. An exception at the head triggers a one-cycle flush,
// then a fixed stall before dispatch resumes into an empty ROB.
//
// State table:
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_RUN     | normal operation: allocate at tail, commit at head
//   ST_EXC     | exception at head seen; flush pulse, ROB cleared on exit
//   ST_RECOVER | post-flush stall for RECOVER_CYCLES cycles, no dispatch
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rob_we      in   [1:0] per-slot allocation strobes from dispatch
//   rob_rdy     out  [1:0] bit0: >=1 free entry, bit1: >=2 free entries
//   wr_idx      out  [2*IW-1:0] slot0 index in [IW-1:0], slot1 in [2*IW-1:IW]
//   head_ready  in   [1:0] ready flags of entries at head and head+1
//   head_exc    in   exception flag of the entry at head
//   commit      out  [1:0] retire strobes for head and head+1
//   head_idx    out  [IW-1:0] current head pointer
//   flush       out  one-cycle pipeline squash pulse
//   count       out  [IW:0] number of occupied entries
// ---------------------------------------------------------------------------
module rob_alloc_ctrl #(
  parameter int ROB_DEPTH      = 32,
  parameter int RECOVER_CYCLES = 2,
  localparam int IW            = $clog2(ROB_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      rob_we,
  output logic [1:0]      rob_rdy,
  output logic [2*IW-1:0] wr_idx,
  input  logic [1:0]      head_ready,
  input  logic            head_exc,
  output logic [1:0]      commit,
  output logic [IW-1:0]   head_idx,
  output logic            flush,
  output logic [IW:0]     count
);

  localparam int CW = IW + 1;
  localparam int SW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_ONE_FREE = CW'(ROB_DEPTH - 1);
  localparam logic [CW-1:0] CNT_TWO_FREE = CW'(ROB_DEPTH - 2);
  localparam logic [SW-1:0] STALL_LOAD   = SW'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_EXC     = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t         state_q;
  logic [IW-1:0]  head_q;
  logic [IW-1:0]  tail_q;
  logic [CW-1:0]  count_q;
  logic [SW-1:0]  stall_q;

  logic           is_run;
  logic           count_ge1;
  logic           count_ge2;
  logic           exc_take;
  logic [1:0]     nalloc_req;
  logic [1:0]     nalloc_cap;
  logic [1:0]     nalloc;
  logic [1:0]     ncommit;

  // -------------------------------------------------------------------------
  // Combinational decode. Everything below looks only at registered state
  // plus the current-cycle inputs; a commit in this cycle never grants
  // allocation credit until the next cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    is_run    = (state_q == ST_RUN);
    count_ge1 = (count_q != '0);
    count_ge2 = (count_q >= CW'(2));

    rob_rdy    = 2'b00;
    rob_rdy[0] = is_run && (count_q <= CNT_ONE_FREE);
    rob_rdy[1] = is_run && (count_q <= CNT_TWO_FREE);

    commit    = 2'b00;
    commit[0] = is_run && count_ge1 && head_ready[0] && !head_exc;
    commit[1] = commit[0] && count_ge2 && head_ready[1];

    exc_take = is_run && count_ge1 && head_ready[0] && head_exc;

    // Strobes beyond the advertised space are dropped: a lone strobe on
    // either slot fits when one entry is free, a pair needs two.
    nalloc_req = {1'b0, rob_we[0]} + {1'b0, rob_we[1]};
    if (rob_rdy[1]) begin
      nalloc_cap = 2'd2;
    end else if (rob_rdy[0]) begin
      nalloc_cap = 2'd1;
    end else begin
      nalloc_cap = 2'd0;
    end
    nalloc = (nalloc_req < nalloc_cap) ? nalloc_req : nalloc_cap;

    ncommit = {1'b0, commit[0]} + {1'b0, commit[1]};
  end

  // Slot1 is offset only when slot0 also allocates, so the lowest set
  // strobe always receives tail.
  assign wr_idx[IW-1:0]    = tail_q;
  assign wr_idx[2*IW-1:IW] = tail_q + IW'(rob_we[0]);

  assign head_idx = head_q;
  assign count    = count_q;
  assign flush    = (state_q == ST_EXC);

  // -------------------------------------------------------------------------
  // Sequencer and pointer state.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          // Allocations in the exception cycle are still taken; the flush
          // that follows discards them together with everything else.
          head_q  <= head_q + IW'(ncommit);
          tail_q  <= tail_q + IW'(nalloc);
          count_q <= count_q + CW'(nalloc) - CW'(ncommit);
          if (exc_take) begin
            state_q <= ST_EXC;
          end
        end
        ST_EXC: begin
          head_q  <= '0;
          tail_q  <= '0;
          count_q <= '0;
          stall_q <= STALL_LOAD;
          state_q <= ST_RECOVER;
        end
        ST_RECOVER: begin
          if (stall_q == '0) begin
            state_q <= ST_RUN;
          end else begin
            stall_q <= stall_q - SW'(1);
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
module tb_rob_alloc_ctrl;

  localparam int IW = 5;

  logic            clk;
  logic            rst_n;
  logic [1:0]      rob_we;
  logic [1:0]      rob_rdy;
  logic [2*IW-1:0] wr_idx;
  logic [1:0]      head_ready;
  logic            head_exc;
  logic [1:0]      commit;
  logic [IW-1:0]   head_idx;
  logic            flush;
  logic [IW:0]     count;

  int n_checks;
  int n_fail;

  rob_alloc_ctrl #(.ROB_DEPTH(32), .RECOVER_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rob_we     (rob_we),
    .rob_rdy    (rob_rdy),
    .wr_idx     (wr_idx),
    .head_ready (head_ready),
    .head_exc   (head_exc),
    .commit     (commit),
    .head_idx   (head_idx),
    .flush      (flush),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]    we;
    logic [1:0]    hr;
    logic          exc;
    logic [1:0]    e_rdy;
    logic [1:0]    e_commit;
    logic [IW-1:0] e_wr0;
    logic [IW-1:0] e_wr1;
    logic [IW-1:0] e_head;
    logic [IW:0]   e_count;
    logic          e_flush;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [1:0] hr, input logic exc);
    rob_we     = we;
    head_ready = hr;
    head_exc   = exc;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic fill_pairs(input int n);
    for (int k = 0; k < n; k++) begin
      drive(2'b11, 2'b00, 1'b0);
      tick();
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    rob_we     = 2'b00;
    head_ready = 2'b00;
    head_exc   = 1'b0;

    //             we     hr    exc   rdy    commit wr0 wr1 head cnt flush
    vecs[0]  = '{2'b00, 2'b11, 1'b1, 2'b11, 2'b00, 0,  0,  0,   0,  1'b0};
    vecs[1]  = '{2'b01, 2'b00, 1'b0, 2'b11, 2'b00, 0,  1,  0,   0,  1'b0};
    vecs[2]  = '{2'b11, 2'b00, 1'b0, 2'b11, 2'b00, 1,  2,  0,   1,  1'b0};
    vecs[3]  = '{2'b00, 2'b10, 1'b0, 2'b11, 2'b00, 3,  3,  0,   3,  1'b0};
    vecs[4]  = '{2'b00, 2'b01, 1'b0, 2'b11, 2'b01, 3,  3,  0,   3,  1'b0};
    vecs[5]  = '{2'b11, 2'b11, 1'b0, 2'b11, 2'b11, 3,  4,  1,   2,  1'b0};
    vecs[6]  = '{2'b10, 2'b00, 1'b0, 2'b11, 2'b00, 5,  5,  3,   2,  1'b0};
    vecs[7]  = '{2'b11, 2'b11, 1'b0, 2'b11, 2'b11, 6,  7,  3,   3,  1'b0};
    vecs[8]  = '{2'b00, 2'b11, 1'b0, 2'b11, 2'b11, 8,  8,  5,   3,  1'b0};
    vecs[9]  = '{2'b00, 2'b11, 1'b0, 2'b11, 2'b01, 8,  8,  7,   1,  1'b0};
    vecs[10] = '{2'b11, 2'b00, 1'b0, 2'b11, 2'b00, 8,  9,  8,   0,  1'b0};
    vecs[11] = '{2'b11, 2'b00, 1'b0, 2'b11, 2'b00, 10, 11, 8,   2,  1'b0};
    vecs[12] = '{2'b11, 2'b01, 1'b1, 2'b11, 2'b00, 12, 13, 8,   4,  1'b0};
    vecs[13] = '{2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 14, 15, 8,   6,  1'b1};
    vecs[14] = '{2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 0,  1,  0,   0,  1'b0};
    vecs[15] = '{2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 0,  1,  0,   0,  1'b0};
    vecs[16] = '{2'b00, 2'b11, 1'b0, 2'b11, 2'b00, 0,  0,  0,   0,  1'b0};

    // Outputs while reset is held.
    #12;
    drive(2'b01, 2'b11, 1'b0);
    chk("rst_wr0_we01", wr_idx[IW-1:0], 0);
    chk("rst_wr1_we01", wr_idx[2*IW-1:IW], 1);
    chk("rst_rdy", rob_rdy, 2'b11);
    chk("rst_commit", commit, 2'b00);
    chk("rst_flush", flush, 0);
    chk("rst_count", count, 0);
    chk("rst_head", head_idx, 0);
    drive(2'b00, 2'b11, 1'b0);
    chk("rst_wr1_we00", wr_idx[2*IW-1:IW], 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven run from reset.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].we, vecs[i].hr, vecs[i].exc);
      chk($sformatf("v%0d_rdy", i), rob_rdy, vecs[i].e_rdy);
      chk($sformatf("v%0d_commit", i), commit, vecs[i].e_commit);
      chk($sformatf("v%0d_wr0", i), wr_idx[IW-1:0], vecs[i].e_wr0);
      chk($sformatf("v%0d_wr1", i), wr_idx[2*IW-1:IW], vecs[i].e_wr1);
      chk($sformatf("v%0d_head", i), head_idx, vecs[i].e_head);
      chk($sformatf("v%0d_count", i), count, vecs[i].e_count);
      chk($sformatf("v%0d_flush", i), flush, vecs[i].e_flush);
      tick();
    end

    // Fill to full, overflow ignored, commit at full frees space next cycle.
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      drive(2'b11, 2'b00, 1'b0);
      chk($sformatf("fill%0d_rdy", k), rob_rdy, 2'b11);
      chk($sformatf("fill%0d_wr0", k), wr_idx[IW-1:0], (2 * k) % 32);
      tick();
    end
    drive(2'b11, 2'b00, 1'b0);
    chk("full_count", count, 32);
    chk("full_rdy", rob_rdy, 2'b00);
    chk("full_tail", wr_idx[IW-1:0], 0);
    tick();
    chk("full_ovf_count", count, 32);
    chk("full_ovf_tail", wr_idx[IW-1:0], 0);
    drive(2'b00, 2'b01, 1'b0);
    chk("full_commit", commit, 2'b01);
    chk("full_commit_rdy", rob_rdy, 2'b00);
    tick();
    chk("full_after_count", count, 31);
    chk("full_after_rdy", rob_rdy, 2'b01);
    chk("full_after_head", head_idx, 1);

    // Odd slot at count 31, tail 31; then a pair with one free entry.
    apply_reset();
    fill_pairs(15);
    drive(2'b01, 2'b00, 1'b0);
    tick();
    drive(2'b10, 2'b00, 1'b0);
    chk("odd_rdy", rob_rdy, 2'b01);
    chk("odd_wr1", wr_idx[2*IW-1:IW], 31);
    tick();
    chk("odd_count", count, 32);
    chk("odd_tail", wr_idx[IW-1:0], 0);
    drive(2'b11, 2'b01, 1'b0);
    chk("odd_full_commit", commit, 2'b01);
    tick();
    chk("odd_freed_count", count, 31);
    drive(2'b11, 2'b00, 1'b0);
    chk("odd_pair_rdy", rob_rdy, 2'b01);
    tick();
    chk("odd_pair_count", count, 32);
    chk("odd_pair_tail", wr_idx[IW-1:0], 1);

    // Tail wrap with a pair at tail 31.
    apply_reset();
    fill_pairs(15);
    drive(2'b01, 2'b11, 1'b0);
    chk("wrap_pre_commit", commit, 2'b11);
    tick();
    chk("wrap_pre_count", count, 29);
    chk("wrap_pre_head", head_idx, 2);
    drive(2'b11, 2'b00, 1'b0);
    chk("wrap_rdy", rob_rdy, 2'b11);
    chk("wrap_wr0", wr_idx[IW-1:0], 31);
    chk("wrap_wr1", wr_idx[2*IW-1:IW], 0);
    tick();
    chk("wrap_count", count, 31);
    chk("wrap_tail", wr_idx[IW-1:0], 1);

    // Simultaneous allocate and commit at count 5.
    apply_reset();
    fill_pairs(2);
    drive(2'b01, 2'b00, 1'b0);
    tick();
    drive(2'b11, 2'b11, 1'b0);
    chk("sim_count_pre", count, 5);
    chk("sim_commit", commit, 2'b11);
    tick();
    drive(2'b00, 2'b00, 1'b0);
    chk("sim_count", count, 5);
    chk("sim_head", head_idx, 2);
    chk("sim_tail", wr_idx[IW-1:0], 7);

    // Reset in the middle of RECOVER.
    apply_reset();
    drive(2'b01, 2'b00, 1'b0);
    tick();
    drive(2'b00, 2'b01, 1'b1);
    chk("rr_exc_commit", commit, 2'b00);
    tick();
    drive(2'b00, 2'b00, 1'b0);
    chk("rr_flush", flush, 1);
    tick();
    chk("rr_recover_rdy", rob_rdy, 2'b00);
    rst_n = 1'b0;
    #1;
    chk("rr_rst_rdy", rob_rdy, 2'b11);
    chk("rr_rst_count", count, 0);
    chk("rr_rst_flush", flush, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(2'b00, 2'b00, 1'b0);
      chk($sformatf("rr_post%0d_flush", k), flush, 0);
      chk($sformatf("rr_post%0d_rdy", k), rob_rdy, 2'b11);
      tick();
    end

    // Reset in the middle of EXC.
    apply_reset();
    drive(2'b01, 2'b00, 1'b0);
    tick();
    drive(2'b00, 2'b01, 1'b1);
    tick();
    drive(2'b00, 2'b00, 1'b0);
    chk("re_flush", flush, 1);
    rst_n = 1'b0;
    #1;
    chk("re_rst_flush", flush, 0);
    chk("re_rst_rdy", rob_rdy, 2'b11);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(2'b00, 2'b00, 1'b0);
      chk($sformatf("re_post%0d_flush", k), flush, 0);
      chk($sformatf("re_post%0d_rdy", k), rob_rdy, 2'b11);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
